// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect definitions.
// The read-side and write-side arbiters both use these state encodings.
package axil_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_t;

endpackage

// File: rtl/axil_rr_pick.sv
// Rotate-priority picker. Returns the first set request at or above i_ptr,
// wrapping N-1 -> 0. i_ptr must be below N.
module axil_rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_none
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_sum;

  // Bit k of w_rot is the request from master (ptr + k) mod N.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    w_sum  = '0;
    for (int k = 0; k < N; k++) begin
      if (o_none && w_rot[k]) begin
        w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
        if (w_sum >= (IDX_W+1)'(N)) begin
          w_sum = w_sum - (IDX_W+1)'(N);
        end
        o_idx  = w_sum[IDX_W-1:0];
        o_none = 1'b0;
      end
    end
    o_onehot = o_none ? '0 : (N'(1) << o_idx);
  end

endmodule

// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin AXI-Lite read arbiter: holds one master's grant from AR request
// through the R handshake; the last-served master gets lowest priority next.
//
// state | meaning
// IDLE  | no grant held; arbitrate on m_axil_arvalid
// ADDR  | grant held, waiting for AR handshake
// DATA  | grant held, waiting for R handshake
module axil_arbiter_rr_rd
  import axil_pkg::*;
#(
  parameter  int NUMBER_MASTER = 4,
  localparam int IDX_W         = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] m_axil_arvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_rready,
  input  logic                     s_axil_arready,
  input  logic                     s_axil_rvalid,
  output logic [NUMBER_MASTER-1:0] grant_rd,
  output logic [IDX_W-1:0]         grant_rd_idx,
  output logic                     busy_rd
);

  rd_arb_state_t            r_state;
  rd_arb_state_t            w_state_nxt;
  logic [NUMBER_MASTER-1:0] r_grant;
  logic [NUMBER_MASTER-1:0] w_grant_nxt;
  logic [IDX_W-1:0]         r_grant_idx;
  logic [IDX_W-1:0]         w_grant_idx_nxt;
  logic [IDX_W-1:0]         r_ptr;
  logic [IDX_W-1:0]         w_ptr_nxt;

  logic [NUMBER_MASTER-1:0] w_pick_onehot;
  logic [IDX_W-1:0]         w_pick_idx;
  logic                     w_pick_none;
  logic                     w_ar_hs;
  logic                     w_r_hs;

  axil_rr_pick #(
    .N (NUMBER_MASTER)
  ) u_pick (
    .i_req    (m_axil_arvalid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_none   (w_pick_none)
  );

  // Grant is one-hot while held, so masking selects the granted master's bit.
  assign w_ar_hs = (|(m_axil_arvalid & r_grant)) && s_axil_arready;
  assign w_r_hs  = (|(m_axil_rready & r_grant)) && s_axil_rvalid;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      IDLE: begin
        if (!w_pick_none) begin
          w_state_nxt     = ADDR;
          w_grant_nxt     = w_pick_onehot;
          w_grant_idx_nxt = w_pick_idx;
        end
      end
      ADDR: begin
        if (w_ar_hs) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_r_hs) begin
          w_state_nxt     = IDLE;
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
          // Explicit wrap so non-power-of-2 counts never point past N-1.
          if (r_grant_idx == IDX_W'(NUMBER_MASTER - 1)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = r_grant_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
      end
    endcase
  end

  assign grant_rd     = r_grant;
  assign grant_rd_idx = r_grant_idx;
  assign busy_rd      = (r_state != IDLE);

endmodule

// File: tb/tb_axil_arbiter_rr_rd.sv
// Directed bench for the round-robin read arbiter with four masters.
module tb_axil_arbiter_rr_rd;

  localparam int N = 4;

  logic         aclk;
  logic         aresetn;
  logic [N-1:0] m_axil_arvalid;
  logic [N-1:0] m_axil_rready;
  logic         s_axil_arready;
  logic         s_axil_rvalid;
  logic [N-1:0] grant_rd;
  logic [1:0]   grant_rd_idx;
  logic         busy_rd;

  int n_checks;
  int n_errors;

  axil_arbiter_rr_rd #(
    .NUMBER_MASTER (N)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_rready  (m_axil_rready),
    .s_axil_arready (s_axil_arready),
    .s_axil_rvalid  (s_axil_rvalid),
    .grant_rd       (grant_rd),
    .grant_rd_idx   (grant_rd_idx),
    .busy_rd        (busy_rd)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [N-1:0] g, input logic [1:0] idx,
                           input logic busy);
    chk({tag, ".grant"}, 32'(grant_rd), 32'(g));
    chk({tag, ".idx"}, 32'(grant_rd_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(busy_rd), 32'(busy));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [N-1:0] oh;
    int           exp_idx;
    n_checks       = 0;
    n_errors       = 0;
    aresetn        = 1'b0;
    m_axil_arvalid = 4'b1111;
    m_axil_rready  = 4'b0000;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk_grant("reset", 4'b0000, 2'd0, 1'b0);
    aresetn = 1'b1;
    tick();
    chk_grant("first_grant", 4'b0001, 2'd0, 1'b1);

    // Rotation with single-cycle slave responses
    s_axil_arready = 1'b1;
    s_axil_rvalid  = 1'b1;
    m_axil_rready  = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      exp_idx = k % 4;
      oh      = 4'b0001 << exp_idx;
      tick();
      chk("rot.data_busy", 32'(busy_rd), 32'd1);
      tick();
      chk_grant("rot.bubble", 4'b0000, 2'd0, 1'b0);
      tick();
      chk_grant("rot.grant", oh, 2'(exp_idx), 1'b1);
    end
    tick();                          // DATA
    m_axil_arvalid = 4'b0000;
    tick();                          // IDLE, ptr=1

    // Skip and wrap
    m_axil_arvalid = 4'b0100;
    tick();
    chk_grant("skip.idx2", 4'b0100, 2'd2, 1'b1);
    tick();                          // DATA
    m_axil_arvalid = 4'b0101;
    tick();                          // IDLE, ptr=3
    chk_grant("skip.bubble", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_grant("wrap.ptr3", 4'b0001, 2'd0, 1'b1);
    tick();                          // DATA
    tick();                          // IDLE, ptr=1
    tick();
    chk_grant("wrap.ptr1", 4'b0100, 2'd2, 1'b1);
    tick();                          // DATA
    m_axil_arvalid = 4'b0000;
    tick();                          // IDLE, ptr=3

    // Hold through stalls
    m_axil_arvalid = 4'b0010;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    m_axil_rready  = 4'b0000;
    tick();
    chk_grant("stall.grant", 4'b0010, 2'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_grant("stall.ar_low", 4'b0010, 2'd1, 1'b1);
    end
    s_axil_arready = 1'b1;
    tick();                          // DATA
    chk_grant("stall.data", 4'b0010, 2'd1, 1'b1);
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b1;
    m_axil_rready  = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_grant("stall.rready_low", 4'b0010, 2'd1, 1'b1);
    end
    m_axil_rready = 4'b1111;
    tick();
    chk_grant("stall.release", 4'b0000, 2'd0, 1'b0);
    m_axil_arvalid = 4'b0000;
    tick();
    chk_grant("idle.no_req", 4'b0000, 2'd0, 1'b0);

    // Ignored events (ptr=2)
    m_axil_arvalid = 4'b0001;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b1;
    tick();
    chk_grant("ign.grant", 4'b0001, 2'd0, 1'b1);
    tick();
    tick();
    chk_grant("ign.rvalid_in_addr", 4'b0001, 2'd0, 1'b1);
    m_axil_arvalid = 4'b0000;
    s_axil_arready = 1'b1;
    tick();
    tick();
    chk_grant("ign.arvalid_drop", 4'b0001, 2'd0, 1'b1);
    m_axil_arvalid = 4'b0001;
    s_axil_rvalid  = 1'b0;
    tick();                          // DATA
    tick();
    chk_grant("ign.arready_in_data", 4'b0001, 2'd0, 1'b1);
    m_axil_arvalid = 4'b0000;
    s_axil_rvalid  = 1'b1;
    tick();                          // IDLE, ptr=1
    chk_grant("ign.release", 4'b0000, 2'd0, 1'b0);

    // Reset mid-DATA
    m_axil_arvalid = 4'b0100;
    s_axil_rvalid  = 1'b0;
    tick();
    tick();
    chk_grant("rst.in_data", 4'b0100, 2'd2, 1'b1);
    aresetn = 1'b0;
    tick();
    chk_grant("rst.abandon", 4'b0000, 2'd0, 1'b0);
    aresetn        = 1'b1;
    m_axil_arvalid = 4'b1100;
    tick();
    chk_grant("rst.regrant", 4'b0100, 2'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_rr_rd.md
# axil_arbiter_rr_rd

Round-robin read-channel arbiter for the AXI-Lite interconnect. It shares one slave read port among NUMBER_MASTER masters and holds each grant from AR request through the R handshake. It drives a registered one-hot grant and a binary index that steer the AR/R muxes. Rotation is fair: the most recently served master gets lowest priority in the next arbitration.

## Interface
Parameters:
- NUMBER_MASTER, 4, number of requesting masters (≥1)
- IDX_W, max(1, $clog2(NUMBER_MASTER)), width of grant index (derived, not overridden)

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- m_axil_arvalid  in  NUMBER_MASTER  per-master read-address valid; acts as the request vector
- m_axil_rready  in  NUMBER_MASTER  per-master read-data ready
- s_axil_arready  in  1  slave read-address ready
- s_axil_rvalid  in  1  slave read-data valid
- grant_rd  out  NUMBER_MASTER  one-hot grant, registered
- grant_rd_idx  out  IDX_W  binary index of granted master, registered
- busy_rd  out  1  high while a grant is held (state ≠ IDLE)

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: if m_axil_arvalid == 0, stay. Otherwise select the first set bit scanning upward from pointer ptr, wrapping N-1→0. Load grant_rd/grant_rd_idx and go to ADDR.
- ADDR: leave when m_axil_arvalid[grant_rd_idx] && s_axil_arready, then go to DATA. Grant is unchanged.
- DATA: leave when s_axil_rvalid && m_axil_rready[grant_rd_idx]. Then go to IDLE, clear grant_rd and grant_rd_idx to 0, and set ptr = grant_rd_idx+1 (wraps to 0 when grant_rd_idx == N-1).
- ptr is internal, IDX_W bits, and is updated only on DATA exit.
- Reset values: state IDLE, grant_rd 0, grant_rd_idx 0, busy_rd 0, ptr 0.
- Boundary conditions:
  - A request deasserted during ADDR (protocol violation) does not release the grant. The arbiter waits.
  - s_axil_rvalid in ADDR is ignored.
  - s_axil_arready in DATA is ignored.
  - Requests arriving while busy are not sampled until IDLE.
  - Reset mid-transaction abandons the grant immediately. The next cycle is IDLE with ptr 0.
  - NUMBER_MASTER=1: IDX_W=1, ptr stays 0, grant_rd_idx always 0.
  - Non-power-of-2 N: ptr wrap is explicit compare to N-1, not modulo-2^IDX_W.

## Timing
- Grant latency: request sampled in IDLE at cycle t gives grant_rd valid at t+1.
- AR handshake at cycle a moves state to DATA at a+1. AR handshake in the same cycle the grant first appears is legal.
- R handshake at cycle r clears the grant at r+1. Earliest re-grant is r+2, a mandatory 1-cycle IDLE bubble.
- Minimum transaction occupancy: 3 cycles (IDLE→ADDR→DATA→IDLE).
- grant_rd and grant_rd_idx are glitch-free registers and always consistent (onehot(idx) or both zero).

## Structure
- Shared package axil_pkg holds state enum rd_arb_state_t {IDLE, ADDR, DATA} (2-bit). This lets the write-side arbiter and interconnect top reuse encodings.
- One sub-module, axil_rr_pick: combinational rotate-priority picker. Inputs are the request vector and ptr; outputs are one-hot and index. Double-width vector scan or masked/unmasked two-pass, with a "none" flag.
- FSM plus ptr register live in axil_arbiter_rr_rd.

## Test plan
- Reset and idle: hold aresetn=0 for 3 cycles with m_axil_arvalid=4'b1111 → grant_rd=0, grant_rd_idx=0, busy_rd=0. Release → grant_rd=4'b0001 one cycle later.
- Rotation: all four requesting continuously, each slave responding with arready and rvalid in 1 cycle → grants in order idx 0,1,2,3,0, each separated by one IDLE cycle.
- Skip and wrap: ptr=3 (after serving idx 2), requests=4'b0101 → grant idx 0. Then ptr=1, requests=4'b0101 → grant idx 2.
- Hold through stalls: grant idx 1, s_axil_arready low for 5 cycles, then rvalid with m_axil_rready[1]=0 for 4 cycles → grant_rd stays 4'b0010 throughout, clears 1 cycle after rready[1]=1.
- Ignored events: s_axil_rvalid=1 in ADDR with rready all 1 → stays ADDR. Requester drops arvalid in ADDR → grant held.
- Reset mid-DATA: grant idx 2 in DATA, assert aresetn=0 for 1 cycle → next cycle grant_rd=0, busy_rd=0. With requests=4'b1100 after release → grant idx 2 (ptr reset to 0).
